// File: rtl/alu_exec_unit.sv
// ALU execution unit: B-operand mux, four-operation ALU with branch-equal
// detection, one-cycle registered copies of the result and branch flag, and a
// free-running 32-bit cycle counter.
module alu_exec_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] aluValA,
    input  logic [31:0] regBvalue,
    input  logic [31:0] offsetExtended,
    input  logic        CONTROL_ALUvalB,
    input  logic [1:0]  CONTROL_OPERATION,
    output logic [31:0] aluValB,
    output logic [31:0] aluResult,
    output logic        CONTROL_BEQ,
    output logic [31:0] result_q,
    output logic        beq_q,
    output logic [31:0] cycle_count
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_NOR  = 2'b01;
    localparam logic [1:0] OP_CMP  = 2'b10;

    logic [31:0] result_d;
    logic        beq_d;
    logic [31:0] cycle_count_q;
    logic [31:0] cycle_count_d;

    // Select the B operand: sign-extended offset for immediate forms, else register B.
    always_comb begin
        aluValB = CONTROL_ALUvalB ? offsetExtended : regBvalue;
    end

    // ALU datapath; any encoding not explicitly decoded (including X/Z) falls to pass-A.
    always_comb begin
        aluResult   = aluValA;
        CONTROL_BEQ = 1'b0;
        case (CONTROL_OPERATION)
            OP_ADD: aluResult = aluValA + aluValB;
            OP_NOR: aluResult = ~(aluValA | aluValB);
            OP_CMP: begin
                aluResult   = aluValA - aluValB;
                CONTROL_BEQ = (aluValA == aluValB);
            end
            default: begin
                aluResult   = aluValA;
                CONTROL_BEQ = 1'b0;
            end
        endcase
    end

    // Next-state values for the registered outputs and the wrapping counter.
    always_comb begin
        result_d      = aluResult;
        beq_d         = CONTROL_BEQ;
        cycle_count_d = cycle_count_q + 32'd1;
    end

    // State registers, cleared asynchronously while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q      <= 32'd0;
            beq_q         <= 1'b0;
            cycle_count_q <= 32'd0;
        end else begin
            result_q      <= result_d;
            beq_q         <= beq_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: a driver applies one operand set per
// cycle on the falling edge, checks the combinational outputs against a
// behavioural model and queues the expected registered response; a monitor
// pops and compares after every rising edge.
module tb_alu_exec_unit;

    logic        clk;
    logic        reset;
    logic [31:0] aluValA;
    logic [31:0] regBvalue;
    logic [31:0] offsetExtended;
    logic        CONTROL_ALUvalB;
    logic [1:0]  CONTROL_OPERATION;
    logic [31:0] aluValB;
    logic [31:0] aluResult;
    logic        CONTROL_BEQ;
    logic [31:0] result_q;
    logic        beq_q;
    logic [31:0] cycle_count;

    alu_exec_unit dut (
        .clk               (clk),
        .reset             (reset),
        .aluValA           (aluValA),
        .regBvalue         (regBvalue),
        .offsetExtended    (offsetExtended),
        .CONTROL_ALUvalB   (CONTROL_ALUvalB),
        .CONTROL_OPERATION (CONTROL_OPERATION),
        .aluValB           (aluValB),
        .aluResult         (aluResult),
        .CONTROL_BEQ       (CONTROL_BEQ),
        .result_q          (result_q),
        .beq_q             (beq_q),
        .cycle_count       (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        beq;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    logic        mon_en = 1'b0;
    logic [31:0] exp_cnt = 32'd0;

    // Reference behaviour written straight from the operation table.
    function automatic logic [31:0] ref_result(logic [31:0] a, logic [31:0] b, logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return ~(a | b);
            2'd2:    return a - b;
            default: return a;
        endcase
    endfunction

    function automatic logic ref_beq(logic [31:0] a, logic [31:0] b, logic [1:0] op);
        return (op == 2'd2) && (a == b);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one operand set, verify the combinational outputs, queue the registered expectation.
    task automatic apply(input logic [31:0] a, input logic [31:0] rb, input logic [31:0] off,
                         input logic sel, input logic [1:0] op);
        logic [31:0] b;
        exp_t        e;
        aluValA           = a;
        regBvalue         = rb;
        offsetExtended    = off;
        CONTROL_ALUvalB   = sel;
        CONTROL_OPERATION = op;
        #1;
        b = sel ? off : rb;
        check("comb_valB", aluValB, b);
        check("comb_result", aluResult, ref_result(a, b, op));
        check("comb_beq", {31'd0, CONTROL_BEQ}, {31'd0, ref_beq(a, b, op)});
        exp_cnt = exp_cnt + 32'd1;
        e.res = ref_result(a, b, op);
        e.beq = ref_beq(a, b, op);
        e.cnt = exp_cnt;
        sb.push_back(e);
        $display("[TB] issue A=%08h rB=%08h off=%08h sel=%0d op=%0d -> res=%08h beq=%0d cnt=%0d",
                 a, rb, off, sel, op, e.res, e.beq, e.cnt);
    endtask

    // Monitor: after every rising edge, compare the registered outputs against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (sb.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL scoreboard_underflow: got empty queue, expected an entry");
                end else begin
                    e = sb.pop_front();
                    check("reg_result_q", result_q, e.res);
                    check("reg_beq_q", {31'd0, beq_q}, {31'd0, e.beq});
                    check("reg_cycle_count", cycle_count, e.cnt);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, rb;
        logic [1:0]  op;
        reset             = 1'b0;
        aluValA           = 32'd0;
        regBvalue         = 32'd0;
        offsetExtended    = 32'd0;
        CONTROL_ALUvalB   = 1'b0;
        CONTROL_OPERATION = 2'd0;

        // Reset state with the clock running; combinational path still live.
        repeat (3) @(negedge clk);
        aluValA = 32'h1234_5678; CONTROL_OPERATION = 2'd3;
        #1;
        check("rst_result_q", result_q, 32'd0);
        check("rst_beq_q", {31'd0, beq_q}, 32'd0);
        check("rst_cycle_count", cycle_count, 32'd0);
        check("rst_comb_result", aluResult, 32'h1234_5678);

        // Release reset and run the directed vectors, one per cycle.
        @(negedge clk);
        reset = 1'b1; mon_en = 1'b1; exp_cnt = 32'd0;
        apply(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2'd0);
        check("add_wrap_res", aluResult, 32'd0);
        check("add_wrap_beq", {31'd0, CONTROL_BEQ}, 32'd0);
        @(negedge clk);
        apply(32'd5, 32'd9, 32'hFFFF_FFFE, 1'b1, 2'd0);
        check("offset_valB", aluValB, 32'hFFFF_FFFE);
        check("offset_res", aluResult, 32'd3);
        @(negedge clk);
        apply(32'h0000_FFFF, 32'h00FF_00FF, 32'd0, 1'b0, 2'd1);
        check("nor_res", aluResult, 32'hFF00_0000);
        @(negedge clk);
        check("count_after_3", cycle_count, 32'd3);
        apply(32'd7, 32'd7, 32'd0, 1'b0, 2'd2);
        check("beq_eq_flag", {31'd0, CONTROL_BEQ}, 32'd1);
        check("beq_eq_res", aluResult, 32'd0);
        @(negedge clk);
        apply(32'd7, 32'd8, 32'd0, 1'b0, 2'd2);
        check("beq_ne_flag", {31'd0, CONTROL_BEQ}, 32'd0);
        check("beq_ne_res", aluResult, 32'hFFFF_FFFF);
        @(negedge clk);
        apply(32'd7, 32'd7, 32'd0, 1'b0, 2'd0);
        check("add_eq_flag", {31'd0, CONTROL_BEQ}, 32'd0);

        // Randomised operands; a quarter of them use equal A/B to exercise the branch flag.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a  = $urandom;
            rb = ($urandom_range(3) == 0) ? a : $urandom;
            op = 2'($urandom_range(3));
            apply(a, rb, ($urandom_range(3) == 0) ? a : $urandom, 1'($urandom_range(1)), op);
        end

        // Counter wrap: preload all-ones, one edge later the count reads zero.
        @(negedge clk);
        force dut.cycle_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_count_q;
        exp_cnt = 32'hFFFF_FFFF;
        apply(32'd1, 32'd2, 32'd0, 1'b0, 2'd0);
        @(negedge clk);
        check("count_wrapped", cycle_count, 32'd0);
        apply(32'd3, 32'd4, 32'd0, 1'b0, 2'd1);

        // Restart from reset, reach count 10 with a nonzero result, then reset between edges.
        @(negedge clk);
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("rerst_cycle_count", cycle_count, 32'd0);
        @(negedge clk);
        reset = 1'b1; mon_en = 1'b1; exp_cnt = 32'd0;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge clk);
            apply($urandom | 32'd1, $urandom, $urandom, 1'b0, 2'd3);
        end
        @(negedge clk);
        mon_en = 1'b0;
        check("pre_async_count", cycle_count, 32'd10);
        check("pre_async_nonzero", {31'd0, (result_q != 32'd0)}, 32'd1);
        aluValA = 32'hCAFE_F00D;
        #2;
        reset = 1'b0;
        #1;
        check("async_result_q", result_q, 32'd0);
        check("async_beq_q", {31'd0, beq_q}, 32'd0);
        check("async_cycle_count", cycle_count, 32'd0);
        check("async_comb_follows", aluResult, 32'hCAFE_F00D);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; the ports SHALL be named clk and reset.
REQ-002 The ports SHALL be as follows:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-low reset.
- aluValA  input  32  operand A (register A value).
- regBvalue  input  32  register B value.
- offsetExtended  input  32  sign-extended 16-bit offset.
- CONTROL_ALUvalB  input  1  B-operand select: 0 = regBvalue, 1 = offsetExtended.
- CONTROL_OPERATION  input  2  ALU operation code.
- aluValB  output  32  selected B operand (combinational).
- aluResult  output  32  ALU result (combinational).
- CONTROL_BEQ  output  1  branch-taken flag (combinational).
- result_q  output  32  aluResult registered.
- beq_q  output  1  CONTROL_BEQ registered.
- cycle_count  output  32  free-running cycle counter.

Function
REQ-003 aluValB SHALL equal offsetExtended when CONTROL_ALUvalB=1, else regBvalue; the path SHALL be purely combinational with no added latency.
REQ-004 CONTROL_OPERATION=00 (add; used by add, lw, sw) SHALL give aluResult = aluValA + aluValB modulo 2^32, with the carry discarded.
REQ-005 CONTROL_OPERATION=01 (nor) SHALL give aluResult = ~(aluValA | aluValB), bitwise over 32 bits.
REQ-006 CONTROL_OPERATION=10 (compare; used by beq) SHALL give aluResult = aluValA - aluValB modulo 2^32.
REQ-007 CONTROL_OPERATION=11 (pass; used by jalr/halt/noop) SHALL give aluResult = aluValA.
REQ-008 CONTROL_BEQ SHALL be 1 only when CONTROL_OPERATION=10 and aluValA == aluValB (all 32 bits); it SHALL be 0 for every other operation, even when the operands are equal.
REQ-009 aluValB, aluResult and CONTROL_BEQ SHALL settle within the same cycle as their inputs; they have no clock dependency.
REQ-010 On each rising clk edge with reset high, result_q SHALL load aluResult and beq_q SHALL load CONTROL_BEQ; the latency is one cycle.
REQ-011 On each rising clk edge with reset high, cycle_count SHALL increment by 1 and wrap from 0xFFFFFFFF to 0x00000000 without stalling.
REQ-012 Operands SHALL be treated as unsigned bit vectors; there SHALL be no overflow or flag output other than CONTROL_BEQ.
REQ-013 X/Z on CONTROL_OPERATION is outside the supported operating range; the design SHALL nonetheless be written to resolve any undefined encoding to the pass operation.

Reset
REQ-014 While reset=0, result_q, beq_q and cycle_count SHALL be 0, asynchronously, independent of clk.
REQ-015 Reset asserted mid-operation SHALL clear the registers immediately; the combinational outputs SHALL continue to follow their inputs.
REQ-016 On the first rising edge after reset deasserts, cycle_count SHALL become 1 and result_q/beq_q SHALL capture the current combinational values.

Verification
REQ-017 Add wrap: A=0xFFFFFFFF, regB=1, sel=0, op=00 -> aluResult=0, CONTROL_BEQ=0; next edge result_q=0.
REQ-018 Offset select: A=5, regB=9, offset=0xFFFFFFFE, sel=1, op=00 -> aluValB=0xFFFFFFFE, aluResult=3.
REQ-019 Nor: A=0x0000FFFF, B=0x00FF00FF, op=01 -> aluResult=0xFF000000.
REQ-020 Branch compare:
- A=B=7, op=10 -> CONTROL_BEQ=1, aluResult=0.
- A=7, B=8, op=10 -> CONTROL_BEQ=0, aluResult=0xFFFFFFFF.
- A=B=7, op=00 -> CONTROL_BEQ=0.
REQ-021 Counter: release reset and run 3 edges -> cycle_count=3; force the count to 0xFFFFFFFF, then one edge -> 0.
REQ-022 Async reset: assert reset=0 between clock edges while cycle_count=10 and result_q nonzero -> both become 0 before the next edge.
